// File: rtl/flitzip_pkg.sv
// Shared types and width helpers for the Flitzip compression-path blocks.
// Holds the min-search FSM state encoding, the index/id widths at default sizing,
// and a clog2 helper that never returns zero for use on port widths.
package flitzip_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    // A width of zero is illegal on a port, so single-entry cases still get one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_INPUT_WIDTH = 128;
    localparam int DEF_D           = 8;
    localparam int DEF_NUM_REQ     = 4;
    localparam int NUM_CHUNKS      = DEF_INPUT_WIDTH / DEF_D;
    localparam int CHUNK_IDX_W     = clog2_min1(NUM_CHUNKS);
    localparam int REQ_ID_W        = clog2_min1(DEF_NUM_REQ);

endpackage

// File: rtl/min_search_sched_if.sv
// Request/response bundle between Flitzip requesters and the min-search engine.
// Ports: req_valid/req_data/req_ready (one lane per requester), resp_* result
// handshake, busy status. master = requesters + consumer, slave = the engine.
interface min_search_sched_if
    import flitzip_pkg::*;
#(
    parameter int INPUT_WIDTH = 128,
    parameter int D           = 8,
    parameter int NUM_REQ     = 4
);
    localparam int IDX_W = clog2_min1(INPUT_WIDTH / D);
    localparam int ID_W  = clog2_min1(NUM_REQ);

    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ*INPUT_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]             req_ready;
    logic                           resp_valid;
    logic                           resp_ready;
    logic [D-1:0]                   resp_min;
    logic [IDX_W-1:0]               resp_idx;
    logic [ID_W-1:0]                resp_id;
    logic                           busy;

    modport master (
        output req_valid, req_data, resp_ready,
        input  req_ready, resp_valid, resp_min, resp_idx, resp_id, busy
    );

    modport slave (
        input  req_valid, req_data, resp_ready,
        output req_ready, resp_valid, resp_min, resp_idx, resp_id, busy
    );

endinterface

// File: rtl/min_search_sched_arb.sv
// Round-robin arbiter: first valid requester at or above i_ptr, wrapping around.
// Latency: purely combinational. Backpressure: none; grant is all-zero when idle.
// Ports: i_valid (request vector), i_ptr (priority start), o_grant (one-hot), o_id.
module rr_arbiter
    import flitzip_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int ID_W   = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_id
);

    logic w_found;

    always_comb begin
        o_grant = '0;
        o_id    = '0;
        w_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // Modulo keeps non-power-of-two requester counts wrapping correctly.
            if (!w_found && i_valid[(int'(i_ptr) + k) % NUM_REQ]) begin
                w_found                                = 1'b1;
                o_grant[(int'(i_ptr) + k) % NUM_REQ]   = 1'b1;
                o_id                                   = ID_W'((int'(i_ptr) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/min_search_sched.sv
// Time-shared minimum-chunk search over round-robin arbitrated request words.
// Latency: accept edge, NUM_CHUNKS/LANES scan cycles, then result held in DONE.
// Backpressure: result held until resp_ready; no request accepted outside IDLE.
// Ports: clk_in, rst_in (async active-high), bus (slave side of min_search_sched_if).
module min_search_sched
    import flitzip_pkg::*;
#(
    parameter int INPUT_WIDTH = 128,
    parameter int D           = 8,
    parameter int NUM_REQ     = 4,
    parameter int LANES       = 4,
    localparam int NUM_CHUNKS = INPUT_WIDTH / D
) (
    input  logic               clk_in,
    input  logic               rst_in,
    min_search_sched_if.slave  bus
);

    localparam int IDX_W = clog2_min1(NUM_CHUNKS);
    localparam int ID_W  = clog2_min1(NUM_REQ);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_SCAN = SCAN;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]             r_state;
    logic [ID_W-1:0]        r_ptr;
    logic [ID_W-1:0]        r_id;
    logic [INPUT_WIDTH-1:0] r_work;
    logic [D-1:0]           r_min;
    logic [IDX_W-1:0]       r_idx;
    logic [IDX_W-1:0]       r_cnt;

    logic [NUM_REQ-1:0]     w_grant;
    logic [ID_W-1:0]        w_gnt_id;
    logic                   w_accept;
    logic                   w_last;
    logic [D-1:0]           w_min;
    logic [IDX_W-1:0]       w_idx;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .i_valid (bus.req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_id    (w_gnt_id)
    );

    // Grant only while idle and out of reset so nothing can look accepted
    // while state is being cleared.
    assign bus.req_ready = (r_state == ST_IDLE && !rst_in) ? w_grant : '0;
    assign w_accept      = |(bus.req_valid & bus.req_ready);
    assign w_last        = (r_cnt == IDX_W'(NUM_CHUNKS - LANES));

    // The work register is shifted down LANES chunks per scan cycle, so the
    // current lanes always sit at the bottom; r_cnt supplies the true index.
    // ">=" lets a later equal chunk win, so ties resolve to the highest index.
    always_comb begin
        w_min = r_min;
        w_idx = r_idx;
        for (int l = 0; l < LANES; l++) begin
            if (w_min >= r_work[l*D +: D]) begin
                w_min = r_work[l*D +: D];
                w_idx = r_cnt + IDX_W'(l);
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_id    <= '0;
            r_work  <= '0;
            r_min   <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_work  <= bus.req_data[w_gnt_id*INPUT_WIDTH +: INPUT_WIDTH];
                        r_id    <= w_gnt_id;
                        r_min   <= '1;
                        r_idx   <= '0;
                        r_cnt   <= '0;
                        r_ptr   <= (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
                        r_state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    r_min  <= w_min;
                    r_idx  <= w_idx;
                    r_cnt  <= r_cnt + IDX_W'(LANES);
                    r_work <= r_work >> (LANES * D);
                    if (w_last) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.resp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.resp_valid = (r_state == ST_DONE);
    assign bus.resp_min   = r_min;
    assign bus.resp_idx   = r_idx;
    assign bus.resp_id    = r_id;
    assign bus.busy       = (r_state != ST_IDLE);

endmodule
